// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampling UART receiver: FSM state codes,
// parity-mode selectors and oversampling constants.
package uart_pkg;

    // Raw 3-bit state codes; the enum below is built on them so that both
    // forms stay in step.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP,
        S_BREAK  = ST_BREAK
    } rx_state_e;

    // Parity-mode selectors for P_PARITY.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Ticks per bit and the tick indices at which the line is sampled.
    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] MID_TICK   = 4'd7;
    localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);

    // Given the XOR of all data bits and the received parity bit, report
    // whether that combination violates the selected parity mode.
    function automatic logic parity_error(input int mode, input logic xor_all);
        if (mode == PAR_EVEN) begin
            return xor_all;
        end
        return !xor_all;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchronizer for the asynchronous rx pin. Resets to the idle
// line level so that reset release never looks like a start edge. Also
// keeps one extra registered copy for falling-edge detection.
module uart_rx_sync #(
    parameter int P_SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rx_s_o,
    output logic rx_prev_o
);

    logic [P_SYNC_STAGES-1:0] sync_q;
    logic                     prev_q;

    // Shift the raw pin through the chain; prev_q lags the synchronized value by one CLK.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[P_SYNC_STAGES-2:0], rx_i};
            prev_q <= sync_q[P_SYNC_STAGES-1];
        end
    end

    assign rx_s_o    = sync_q[P_SYNC_STAGES-1];
    assign rx_prev_o = prev_q;

endmodule

// File: rtl/uart_rx_x16.sv
// UART receiver driven by a 16x baud tick. Finds the start edge, checks the
// start bit at mid-bit, then samples data/parity/stop bits every 16 ticks.
// Outputs one-CLK valid / frame_err strobes with the word held on data_out.
module uart_rx_x16
    import uart_pkg::*;
#(
    parameter int P_DATA_BITS   = 8,
    parameter int P_PARITY      = 0,
    parameter int P_SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   tick_x16,
    input  logic                   rx,
    output logic [P_DATA_BITS-1:0] data_out,
    output logic                   valid,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   busy
);

    localparam logic       HAS_PARITY = (P_PARITY != PAR_NONE);
    localparam logic [3:0] LAST_BIT   = 4'(P_DATA_BITS - 1);

    logic rx_s;
    logic rx_prev;

    rx_state_e              state_q;
    logic [3:0]             tick_cnt_q;
    logic [3:0]             bit_cnt_q;
    logic [P_DATA_BITS-1:0] shift_q;
    logic                   err_p_q;
    logic                   done_q;     // good stop bit seen; publish the word next CLK
    logic [P_DATA_BITS-1:0] data_q;
    logic                   valid_q;
    logic                   perr_q;
    logic                   ferr_q;

    uart_rx_sync #(
        .P_SYNC_STAGES (P_SYNC_STAGES)
    ) u_sync (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .rx_i      (rx),
        .rx_s_o    (rx_s),
        .rx_prev_o (rx_prev)
    );

    // Frame FSM: tick counting, bit sampling, shift register and output strobes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            err_p_q    <= 1'b0;
            done_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless set again below.
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;

            // The FSM is already back in IDLE here, so a new start edge can
            // be accepted in the same cycle the word is published.
            if (done_q) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
                perr_q  <= err_p_q;
            end

            case (state_q)
                S_IDLE: begin
                    tick_cnt_q <= '0;
                    if (rx_prev && !rx_s) begin
                        state_q <= S_START;
                    end
                end

                // Confirm the start bit at its centre; a high line means a glitch.
                S_START: begin
                    if (tick_x16) begin
                        if (tick_cnt_q == MID_TICK) begin
                            if (rx_s) begin
                                state_q <= S_IDLE;
                            end else begin
                                tick_cnt_q <= '0;
                                bit_cnt_q  <= '0;
                                err_p_q    <= 1'b0;
                                state_q    <= S_DATA;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                        end
                    end
                end

                // From here on the counter free-runs 0..15 so each sample
                // lands 16 ticks after the previous mid-bit point.
                S_DATA: begin
                    if (tick_x16) begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (tick_cnt_q == LAST_TICK) begin
                            shift_q   <= {rx_s, shift_q[P_DATA_BITS-1:1]};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q <= HAS_PARITY ? S_PARITY : S_STOP;
                            end
                        end
                    end
                end

                S_PARITY: begin
                    if (tick_x16) begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (tick_cnt_q == LAST_TICK) begin
                            err_p_q <= parity_error(P_PARITY, ^{shift_q, rx_s});
                            state_q <= S_STOP;
                        end
                    end
                end

                // Return to IDLE at mid-stop so back-to-back frames need no gap.
                S_STOP: begin
                    if (tick_x16) begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (tick_cnt_q == LAST_TICK) begin
                            if (rx_s) begin
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= S_BREAK;
                            end
                        end
                    end
                end

                // A held-low line must return high before another frame is accepted.
                S_BREAK: begin
                    if (rx_s) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_x16.sv
// Bench for uart_rx_x16: one instance without parity, one with even parity.
// Frames are described at bit level; the model predicts per-frame events.
module tb_uart_rx_x16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick_x16 = 1'b0;
    logic rx0 = 1'b1;
    logic rx2 = 1'b1;

    logic [7:0] dout0, dout2;
    logic v0, v2, pe0, pe2, fe0, fe2, b0, b2;

    uart_rx_x16 #(.P_DATA_BITS(8), .P_PARITY(0), .P_SYNC_STAGES(2)) u0 (
        .CLK(clk), .RST_N(rst_n), .tick_x16(tick_x16), .rx(rx0),
        .data_out(dout0), .valid(v0), .parity_err(pe0), .frame_err(fe0), .busy(b0));

    uart_rx_x16 #(.P_DATA_BITS(8), .P_PARITY(2), .P_SYNC_STAGES(2)) u2 (
        .CLK(clk), .RST_N(rst_n), .tick_x16(tick_x16), .rx(rx2),
        .data_out(dout2), .valid(v2), .parity_err(pe2), .frame_err(fe2), .busy(b2));

    initial forever #5 clk = ~clk;

    // tick every 4 CLK
    initial begin
        forever begin
            repeat (3) begin @(negedge clk); tick_x16 = 1'b0; end
            @(negedge clk); tick_x16 = 1'b1;
        end
    end

    int cyc = 0;
    initial forever begin @(posedge clk); cyc++; end

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        int         ch;
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         stop_cyc;
    } ev_t;

    ev_t        expq[$];
    logic [7:0] mdl_dout [2];
    int         vcnt [2];
    int         fcnt [2];
    logic       last_pe [2];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Per-channel comparison against the frame-level model.
    task automatic check_ch(input int ch, input logic v, input logic pe, input logic fe,
                            input logic [7:0] d);
        ev_t e;
        int  lat;
        if (v || fe) begin
            if (expq.size() == 0 || expq[0].ch != ch) begin
                chk($sformatf("unexpected_event_ch%0d", ch), 1, 0);
            end else begin
                e   = expq.pop_front();
                lat = cyc - e.stop_cyc;
                chk($sformatf("event_fe_ch%0d", ch), fe, e.fe);
                chk($sformatf("event_v_ch%0d", ch), v, !e.fe);
                if (!e.fe) begin
                    // stop bit centre is 32 CLK into the bit, plus sync and one-CLK publish
                    chk($sformatf("latency_valid_ch%0d", ch), int'(lat >= 30 && lat <= 36), 1);
                    chk($sformatf("parity_err_ch%0d", ch), pe, e.pe);
                    mdl_dout[ch] = e.d;
                    vcnt[ch]++;
                    last_pe[ch] = pe;
                end else begin
                    chk($sformatf("latency_ferr_ch%0d", ch), int'(lat >= 29 && lat <= 35), 1);
                    fcnt[ch]++;
                end
            end
        end
        if (!v) chk($sformatf("perr_idle_ch%0d", ch), pe, 0);
        chk($sformatf("data_out_ch%0d", ch), d, mdl_dout[ch]);
    endtask

    // compare process: 3 ns after every rising edge
    initial begin
        mdl_dout[0] = 8'h00; mdl_dout[1] = 8'h00;
        vcnt[0] = 0; vcnt[1] = 0; fcnt[0] = 0; fcnt[1] = 0;
        last_pe[0] = 1'b0; last_pe[1] = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (!rst_n) begin
                chk("rst_outputs", int'({dout0, v0, pe0, fe0, b0, dout2, v2, pe2, fe2, b2} == '0), 1);
                mdl_dout[0] = 8'h00;
                mdl_dout[1] = 8'h00;
            end else begin
                check_ch(0, v0, pe0, fe0, dout0);
                check_ch(1, v2, pe2, fe2, dout2);
            end
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!tick_x16);
        end
    endtask

    task automatic set_rx(input int ch, input logic b);
        @(negedge clk);
        if (ch == 0) rx0 = b; else rx2 = b;
    endtask

    task automatic send_frame(input int ch, input logic [7:0] d, input bit par,
                              input logic pbit, input logic stopb);
        ev_t e;
        set_rx(ch, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            set_rx(ch, d[i]);
            wait_ticks(16);
        end
        if (par) begin
            set_rx(ch, pbit);
            wait_ticks(16);
        end
        set_rx(ch, stopb);
        e.ch       = ch;
        e.d        = d;
        e.pe       = par ? ^{d, pbit} : 1'b0;   // even parity: odd count of ones is an error
        e.fe       = !stopb;
        e.stop_cyc = cyc;
        expq.push_back(e);
        wait_ticks(16);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (5) @(negedge clk);
        #1 chk("reset_busy0", b0, 0);
        chk("reset_dout0", dout0, 0);
        @(negedge clk) rst_n = 1'b1;
        wait_ticks(4);

        // basic 8N1 reception
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
        #1 chk("basic_vcnt", vcnt[0], 1);
        chk("basic_data", dout0, 8'hA5);
        chk("basic_perr", last_pe[0], 0);
        chk("basic_fcnt", fcnt[0], 0);
        chk("basic_busy", b0, 0);

        // glitch of 5 ticks
        wait_ticks(4);
        set_rx(0, 1'b0);
        wait_ticks(2);
        #1 chk("glitch_busy_hi", b0, 1);
        wait_ticks(3);
        set_rx(0, 1'b1);
        wait_ticks(4);
        #1 chk("glitch_busy_lo", b0, 0);
        chk("glitch_vcnt", vcnt[0], 1);
        chk("glitch_fcnt", fcnt[0], 0);

        // framing error then break
        wait_ticks(4);
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0);
        wait_ticks(40);
        #1 chk("break_fcnt", fcnt[0], 1);
        chk("break_vcnt", vcnt[0], 1);
        chk("break_data_kept", dout0, 8'hA5);
        chk("break_busy_hi", b0, 1);
        set_rx(0, 1'b1);
        wait_ticks(1);
        #1 chk("break_busy_lo", b0, 0);

        // back-to-back frames
        wait_ticks(8);
        send_frame(0, 8'h55, 0, 1'b0, 1'b1);
        #1 chk("b2b_first", dout0, 8'h55);
        send_frame(0, 8'hAA, 0, 1'b0, 1'b1);
        #1 chk("b2b_second", dout0, 8'hAA);
        chk("b2b_vcnt", vcnt[0], 3);
        chk("b2b_fcnt", fcnt[0], 1);

        // even parity instance
        wait_ticks(4);
        send_frame(1, 8'h0F, 1, 1'b1, 1'b1);
        #1 chk("par_0f_p1_err", last_pe[1], 1);
        chk("par_0f_p1_data", dout2, 8'h0F);
        send_frame(1, 8'h0F, 1, 1'b0, 1'b1);
        #1 chk("par_0f_p0_err", last_pe[1], 0);
        send_frame(1, 8'h07, 1, 1'b0, 1'b1);
        #1 chk("par_07_p0_err", last_pe[1], 1);
        send_frame(1, 8'h07, 1, 1'b1, 1'b1);
        #1 chk("par_07_p1_err", last_pe[1], 0);
        chk("par_vcnt", vcnt[1], 4);
        chk("par_fcnt", fcnt[1], 0);

        // reset during data bit 3 of 0xFF
        wait_ticks(4);
        set_rx(0, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            set_rx(0, 1'b1);
            wait_ticks(16);
        end
        set_rx(0, 1'b1);
        wait_ticks(8);
        #1 chk("midrst_busy_pre", b0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("midrst_dout", dout0, 0);
        chk("midrst_busy", b0, 0);
        chk("midrst_flags", int'({v0, pe0, fe0}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(4);
        send_frame(0, 8'h81, 0, 1'b0, 1'b1);
        #1 chk("postrst_data", dout0, 8'h81);
        chk("postrst_vcnt", vcnt[0], 4);
        chk("postrst_fcnt", fcnt[0], 1);

        wait_ticks(4);
        #1 chk("no_pending_events", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
